dcache_ctrl: RTL and testbench

Direct-mapped, write-back, write-allocate data cache controller between the MEM stage and off-chip data memory. It serves 32-bit CPU loads and stores from a 16-line × 256-bit store. On a miss it writes back a dirty victim and refills the line over a req/ack memory handshake. While a miss is in flight it drives `mem_stall_o`, which freezes every pipeline register, including ID/EX, through their `MemStall_i` inputs.

---
 rtl/dcache_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_dcache_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller (16 x 256-bit lines).
// A miss writes back a dirty victim, then refills the line over a req/ack memory handshake.
module dcache_ctrl #(
    parameter int LINES  = 16,
    parameter int LINE_W = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_req_i,
    input  logic              cpu_write_i,
    input  logic [31:0]       cpu_addr_i,
    input  logic [31:0]       cpu_wdata_i,
    output logic [31:0]       cpu_rdata_o,
    output logic              mem_stall_o,
    output logic              mem_req_o,
    output logic              mem_write_o,
    output logic [31:0]       mem_addr_o,
    output logic [LINE_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [LINE_W-1:0] mem_rdata_i
);
    localparam int IDX_W  = $clog2(LINES);
    localparam int OFF_W  = $clog2(LINE_W / 8);
    localparam int WORDS  = LINE_W / 32;
    localparam int WSEL_W = $clog2(WORDS);
    localparam int TAG_W  = 32 - IDX_W - OFF_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WB,
        S_ALLOC,
        S_FILL
    } state_t;

    state_t            state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_write_q, mem_write_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic [LINES-1:0]  valid_q, valid_d;
    logic [LINES-1:0]  dirty_q, dirty_d;

    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [LINE_W-1:0] data_mem [LINES];

    logic [TAG_W-1:0]  addr_tag;
    logic [IDX_W-1:0]  addr_idx;
    logic [WSEL_W-1:0] addr_word;
    logic [31:0]       fetch_addr;
    logic              unused_addr_bits;

    assign addr_tag         = cpu_addr_i[31 -: TAG_W];
    assign addr_idx         = cpu_addr_i[OFF_W +: IDX_W];
    assign addr_word        = cpu_addr_i[2 +: WSEL_W];
    assign fetch_addr       = {cpu_addr_i[31:OFF_W], {OFF_W{1'b0}}};
    assign unused_addr_bits = ^cpu_addr_i[1:0];

    logic [TAG_W-1:0]  victim_tag;
    logic [LINE_W-1:0] victim_line;
    logic              hit;
    logic [31:0]       line_words [WORDS];
    logic [LINE_W-1:0] store_line;

    assign victim_tag  = tag_mem[addr_idx];
    assign victim_line = data_mem[addr_idx];
    assign hit         = valid_q[addr_idx] & (victim_tag == addr_tag);

    // Split the selected line into words for the load mux, and build the store-merged line.
    for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
        assign line_words[gi] = victim_line[gi*32 +: 32];
        assign store_line[gi*32 +: 32] = (addr_word == WSEL_W'(gi)) ? cpu_wdata_i
                                                                    : victim_line[gi*32 +: 32];
    end

    assign cpu_rdata_o = line_words[addr_word];
    assign mem_stall_o = (state_q != S_IDLE) | (cpu_req_i & ~hit);

    logic fill_en;
    logic store_en;

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        line_d      = line_q;
        fill_en     = 1'b0;
        store_en    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cpu_req_i) begin
                    if (hit) begin
                        store_en = cpu_write_i;
                    end else if (valid_q[addr_idx] & dirty_q[addr_idx]) begin
                        state_d     = S_WB;
                        mem_req_d   = 1'b1;
                        mem_write_d = 1'b1;
                        mem_addr_d  = {victim_tag, addr_idx, {OFF_W{1'b0}}};
                        mem_wdata_d = victim_line;
                    end else begin
                        state_d     = S_ALLOC;
                        mem_req_d   = 1'b1;
                        mem_write_d = 1'b0;
                        mem_addr_d  = fetch_addr;
                    end
                end
            end
            S_WB: begin
                // Request drops for one cycle; ALLOC re-raises it with the fetch address.
                if (mem_req_q & mem_ack_i) begin
                    state_d   = S_ALLOC;
                    mem_req_d = 1'b0;
                end
            end
            S_ALLOC: begin
                if (!mem_req_q) begin
                    mem_req_d   = 1'b1;
                    mem_write_d = 1'b0;
                    mem_addr_d  = fetch_addr;
                end else if (mem_ack_i) begin
                    mem_req_d = 1'b0;
                    line_d    = mem_rdata_i;
                    state_d   = S_FILL;
                end
            end
            S_FILL: begin
                fill_en = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    for (genvar gi = 0; gi < LINES; gi++) begin : g_line_state
        logic sel;
        assign sel          = (addr_idx == IDX_W'(gi));
        assign valid_d[gi]  = valid_q[gi] | (fill_en & sel);
        assign dirty_d[gi]  = (fill_en & sel) ? 1'b0 :
                              (store_en & sel) ? 1'b1 : dirty_q[gi];
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= S_IDLE;
            mem_req_q   <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            line_q      <= '0;
            valid_q     <= '0;
            dirty_q     <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            line_q      <= line_d;
            valid_q     <= valid_d;
            dirty_q     <= dirty_d;
        end
    end

    // Tag/data store has no reset; valid bits gate every use of it.
    always_ff @(posedge clk_i) begin
        if (fill_en) begin
            tag_mem[addr_idx]  <= addr_tag;
            data_mem[addr_idx] <= line_q;
        end else if (store_en) begin
            data_mem[addr_idx] <= store_line;
        end
    end

    assign mem_req_o   = mem_req_q;
    assign mem_write_o = mem_write_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed vector table, reset-during-miss sequence,
// and randomized accesses against a flat word-addressed memory model with a latency-L responder.
module tb_dcache_ctrl;
    logic         clk_i = 1'b0;
    logic         rst_i = 1'b0;
    logic         cpu_req_i = 1'b0;
    logic         cpu_write_i = 1'b0;
    logic [31:0]  cpu_addr_i = '0;
    logic [31:0]  cpu_wdata_i = '0;
    logic [31:0]  cpu_rdata_o;
    logic         mem_stall_o;
    logic         mem_req_o;
    logic         mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_wdata_o;
    logic         mem_ack_i;
    logic [255:0] mem_rdata_i;

    always #5 clk_i = ~clk_i;

    dcache_ctrl #(.LINES(16), .LINE_W(256)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .cpu_req_i  (cpu_req_i),
        .cpu_write_i(cpu_write_i),
        .cpu_addr_i (cpu_addr_i),
        .cpu_wdata_i(cpu_wdata_i),
        .cpu_rdata_o(cpu_rdata_o),
        .mem_stall_o(mem_stall_o),
        .mem_req_o  (mem_req_o),
        .mem_write_o(mem_write_o),
        .mem_addr_o (mem_addr_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_ack_i  (mem_ack_i),
        .mem_rdata_i(mem_rdata_i)
    );

    int errors = 0;
    int checks = 0;
    int lat = 2;

    int           wb_count = 0;
    int           fetch_count = 0;
    logic [31:0]  last_wb_addr = '0;
    logic [31:0]  last_fetch_addr = '0;
    logic [255:0] last_wb_data = '0;

    logic [255:0] backing [int unsigned];
    logic [31:0]  ref_mem [int unsigned];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [255:0] get_line(input logic [31:0] la);
        logic [255:0] l;
        if (backing.exists(la >> 5)) return backing[la >> 5];
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = init_word({la[31:5], 5'd0} + 32'(4 * w));
        return l;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        if (ref_mem.exists(a >> 2)) return ref_mem[a >> 2];
        return init_word({a[31:2], 2'b00});
    endfunction

    // Memory responder: ack exactly lat cycles after the first request cycle.
    int           r_age = 0;
    logic         r_prev_req = 1'b0;
    logic         r_prev_ack = 1'b0;
    logic [31:0]  r_addr = '0;
    logic         r_write = 1'b0;
    logic [255:0] r_wdata = '0;

    initial begin
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;
        forever begin
            @(posedge clk_i);
            #1;
            mem_ack_i = 1'b0;
            if (!rst_i) begin
                r_age      = 0;
                r_prev_req = 1'b0;
                r_prev_ack = 1'b0;
            end else begin
                if (r_prev_ack) begin
                    chk("req_low_after_ack", 256'(mem_req_o), 256'(0));
                end else if (r_prev_req) begin
                    chk("req_held_until_ack", 256'(mem_req_o), 256'(1));
                    chk("addr_held", 256'(mem_addr_o), 256'(r_addr));
                    chk("write_held", 256'(mem_write_o), 256'(r_write));
                    chk("wdata_held", mem_wdata_o, r_wdata);
                end
                if (mem_req_o && !r_prev_req) begin
                    r_age   = 0;
                    r_addr  = mem_addr_o;
                    r_write = mem_write_o;
                    r_wdata = mem_wdata_o;
                    if (mem_write_o) begin
                        wb_count++;
                        last_wb_addr = mem_addr_o;
                        last_wb_data = mem_wdata_o;
                    end else begin
                        fetch_count++;
                        last_fetch_addr = mem_addr_o;
                    end
                end
                r_prev_ack = 1'b0;
                if (mem_req_o) begin
                    if (r_age == lat) begin
                        mem_ack_i  = 1'b1;
                        r_prev_ack = 1'b1;
                        if (mem_write_o) backing[mem_addr_o >> 5] = mem_wdata_o;
                        else mem_rdata_i = get_line(mem_addr_o);
                    end else begin
                        r_age++;
                    end
                end
                r_prev_req = mem_req_o;
            end
        end
    end

    // Called at posedge+#1; returns after the access completes at a clock edge.
    task automatic access(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output int stalls);
        cpu_req_i   = 1'b1;
        cpu_write_i = wr;
        cpu_addr_i  = a;
        cpu_wdata_i = wd;
        stalls      = 0;
        rd          = 'x;
        forever begin
            @(negedge clk_i);
            if (!mem_stall_o) begin
                rd = cpu_rdata_o;
                break;
            end
            stalls++;
            if (stalls > 500) begin
                checks++;
                errors++;
                $display("FAIL access_timeout: addr %0h still stalled after %0d cycles", a, stalls);
                break;
            end
        end
        @(posedge clk_i);
        #1;
        cpu_req_i = 1'b0;
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int          exp_stall;
        int          exp_wb;
        int          exp_fetch;
        logic [31:0] exp_wb_addr;
        logic [31:0] exp_fetch_addr;
        int          wb_word;
        logic [31:0] exp_wb_word;
    } vec_t;

    function automatic vec_t mk(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] exp_rdata, input int exp_stall,
                                input int exp_wb, input logic [31:0] wb_addr,
                                input int exp_fetch, input logic [31:0] fetch_addr,
                                input int wb_word, input logic [31:0] wb_val);
        vec_t v;
        v.wr = wr; v.addr = addr; v.wdata = wdata; v.exp_rdata = exp_rdata;
        v.exp_stall = exp_stall; v.exp_wb = exp_wb; v.exp_fetch = exp_fetch;
        v.exp_wb_addr = wb_addr; v.exp_fetch_addr = fetch_addr;
        v.wb_word = wb_word; v.exp_wb_word = wb_val;
        return v;
    endfunction

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        vec_t        vecs[$];
        logic [31:0] rd;
        int          st;
        int          wb0;
        int          f0;
        int          lats[2];
        logic        wr;
        logic [31:0] a;
        logic [31:0] wd;
        logic        legal;

        // Reset state
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_req", 256'(mem_req_o), 256'(0));
        chk("rst_stall", 256'(mem_stall_o), 256'(0));
        @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        chk("post_rst_req", 256'(mem_req_o), 256'(0));
        chk("post_rst_write", 256'(mem_write_o), 256'(0));
        chk("post_rst_addr", 256'(mem_addr_o), 256'(0));
        chk("post_rst_wdata", mem_wdata_o, 256'(0));
        chk("post_rst_stall_idle", 256'(mem_stall_o), 256'(0));
        cpu_req_i  = 1'b1;
        cpu_addr_i = 32'h0000_0104;
        #1;
        chk("post_rst_stall_req", 256'(mem_stall_o), 256'(1));
        cpu_req_i = 1'b0;
        #1;

        // Directed vectors at L=2: clean miss 3+L, dirty miss 5+2L
        lat = 2;
        vecs.push_back(mk(0, 32'h104, 0, init_word(32'h104), 5, 0, 0, 1, 32'h100, -1, 0));
        vecs.push_back(mk(1, 32'h104, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, -1, 0));
        vecs.push_back(mk(0, 32'h104, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0, -1, 0));
        vecs.push_back(mk(0, 32'h304, 0, init_word(32'h304), 9, 1, 32'h100, 1, 32'h300, 1, 32'hDEADBEEF));
        vecs.push_back(mk(1, 32'h500, 32'hCAFEF00D, 0, 5, 0, 0, 1, 32'h500, -1, 0));
        vecs.push_back(mk(0, 32'h500, 0, 32'hCAFEF00D, 0, 0, 0, 0, 0, -1, 0));
        vecs.push_back(mk(0, 32'h504, 0, init_word(32'h504), 0, 0, 0, 0, 0, -1, 0));
        vecs.push_back(mk(0, 32'h100, 0, init_word(32'h100), 9, 1, 32'h500, 1, 32'h100, 0, 32'hCAFEF00D));
        vecs.push_back(mk(0, 32'h104, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0, -1, 0));
        vecs.push_back(mk(0, 32'h020, 0, init_word(32'h020), 5, 0, 0, 1, 32'h020, -1, 0));
        vecs.push_back(mk(1, 32'h03C, 32'h1111_2222, 0, 0, 0, 0, 0, 0, -1, 0));
        vecs.push_back(mk(0, 32'h03C, 0, 32'h1111_2222, 0, 0, 0, 0, 0, -1, 0));

        foreach (vecs[i]) begin
            wb0 = wb_count;
            f0  = fetch_count;
            access(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, st);
            $display("vec %0d: %s addr=%0h stall=%0d rdata=%0h", i, vecs[i].wr ? "ST" : "LD",
                     vecs[i].addr, st, rd);
            if (vecs[i].wr) ref_mem[vecs[i].addr >> 2] = vecs[i].wdata;
            chk($sformatf("vec%0d_stall", i), 256'(st), 256'(vecs[i].exp_stall));
            chk($sformatf("vec%0d_wb_count", i), 256'(wb_count - wb0), 256'(vecs[i].exp_wb));
            chk($sformatf("vec%0d_fetch_count", i), 256'(fetch_count - f0), 256'(vecs[i].exp_fetch));
            if (!vecs[i].wr) chk($sformatf("vec%0d_rdata", i), 256'(rd), 256'(vecs[i].exp_rdata));
            if (vecs[i].exp_wb > 0)
                chk($sformatf("vec%0d_wb_addr", i), 256'(last_wb_addr), 256'(vecs[i].exp_wb_addr));
            if (vecs[i].exp_fetch > 0)
                chk($sformatf("vec%0d_fetch_addr", i), 256'(last_fetch_addr), 256'(vecs[i].exp_fetch_addr));
            if (vecs[i].wb_word >= 0)
                chk($sformatf("vec%0d_wb_word", i), 256'(last_wb_data[vecs[i].wb_word*32 +: 32]),
                    256'(vecs[i].exp_wb_word));
        end

        // Reset during ALLOC (L=10, cycle 4): request drops asynchronously, nothing installed
        lat = 10;
        cpu_req_i   = 1'b1;
        cpu_write_i = 1'b0;
        cpu_addr_i  = 32'h0000_2044;
        repeat (4) @(posedge clk_i);
        #2;
        chk("alloc_req_before_reset", 256'(mem_req_o), 256'(1));
        rst_i = 1'b0;
        #1;
        chk("req_async_drop", 256'(mem_req_o), 256'(0));
        backing.delete();
        ref_mem.delete();
        cpu_req_i = 1'b0;
        #1;
        chk("stall_in_reset_no_req", 256'(mem_stall_o), 256'(0));
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        f0 = fetch_count;
        access(1'b0, 32'h0000_2044, 32'h0, rd, st);
        $display("reset-replay: LD addr=2044 stall=%0d rdata=%0h", st, rd);
        chk("replay_stall", 256'(st), 256'(13));
        chk("replay_fetch_count", 256'(fetch_count - f0), 256'(1));
        chk("replay_fetch_addr", 256'(last_fetch_addr), 256'(32'h2040));
        chk("replay_rdata", 256'(rd), 256'(init_word(32'h2044)));

        // Random sweep against the flat memory model
        lats[0] = 0;
        lats[1] = 20;
        for (int li = 0; li < 2; li++) begin
            lat = lats[li];
            for (int n = 0; n < 100; n++) begin
                wr = ($urandom_range(0, 9) < 4);
                a  = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 3)) << 5) |
                     (32'($urandom_range(0, 7)) << 2);
                wd = $urandom;
                access(wr, a, wd, rd, st);
                $display("rand L=%0d #%0d: %s addr=%0h wdata=%0h rdata=%0h stall=%0d", lat, n,
                         wr ? "ST" : "LD", a, wd, rd, st);
                legal = (st == 0) || (st == 3 + lat) || (st == 5 + 2 * lat);
                chk("rand_stall_legal", 256'(legal), 256'(1));
                if (wr) ref_mem[a >> 2] = wd;
                else chk("rand_load", 256'(rd), 256'(ref_read(a)));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
